// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD_if SPI sequencer: FSM encoding,
// chip-enable codes and the EADOGS102N-6 init command table.
package lcd_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_FETCH,
        S_READY,
        S_WR_GO,
        S_WR_DAT,
        S_WAIT_IRQ,
        S_WR_CLR,
        S_GAP,
        S_ERROR
    } state_t;

    localparam logic [1:0] CE_CTRL = 2'b01;
    localparam logic [1:0] CE_DATA = 2'b10;

    // bit8 = C/D, bits7:0 = payload
    typedef logic [8:0] word_t;

    localparam int INIT_ROM_LEN = 11;

    // All init entries are commands (C/D = 0); out-of-range reads give 0.
    function automatic word_t init_rom(input logic [7:0] idx);
        case (idx)
            8'd0:    return 9'h040;
            8'd1:    return 9'h0A1;
            8'd2:    return 9'h0C0;
            8'd3:    return 9'h0A4;
            8'd4:    return 9'h0A6;
            8'd5:    return 9'h0A2;
            8'd6:    return 9'h02F;
            8'd7:    return 9'h027;
            8'd8:    return 9'h081;
            8'd9:    return 9'h010;
            8'd10:   return 9'h0AF;
            default: return 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/lcd_seq_buswr.sv
// One IPIF write cycle: holds WrCE/BE/Data until WrAck, then forces one idle
// cycle before reporting done, with an optional no-ack timeout.
module lcd_seq_buswr
    import lcd_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  ce,
    input  logic [31:0] data,
    input  logic        ack,
    output logic [1:0]  wr_ce,
    output logic [3:0]  be,
    output logic [31:0] wr_data,
    output logic        done,
    output logic        timeout
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    logic        active;
    logic        gap;
    logic [31:0] cnt;

    // An ack on the last allowed cycle still wins over the timeout.
    assign timeout = active && !ack && (TIMEOUT_CYC != 0) && (cnt == TO_LAST);
    assign done    = gap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ce   <= 2'b00;
            be      <= 4'h0;
            wr_data <= 32'h0;
            active  <= 1'b0;
            gap     <= 1'b0;
            cnt     <= 32'h0;
        end else begin
            gap <= 1'b0;
            if (start) begin
                wr_ce   <= ce;
                be      <= 4'hF;
                wr_data <= data;
                active  <= 1'b1;
                cnt     <= 32'h0;
            end else if (active) begin
                if (ack || timeout) begin
                    wr_ce   <= 2'b00;
                    be      <= 4'h0;
                    wr_data <= 32'h0;
                    active  <= 1'b0;
                    gap     <= ack;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_seq.sv
// Bus-master sequencer for LCD_if: power-up wait, init table streaming, then
// user words, each sent as control write / data write / irq wait / irq clear.
module lcd_spi_seq
    import lcd_seq_pkg::*;
#(
    parameter int          PWR_WAIT_CYC = 16,
    parameter int          TIMEOUT_CYC  = 1024,
    parameter logic [31:0] CTRL_GO      = 32'h0000_0E04,
    parameter logic [31:0] CTRL_CLR     = 32'h0000_0F01,
    parameter int          INIT_LEN     = 11
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Reset,
    input  logic        i_start,
    input  logic [8:0]  i_word,
    input  logic        i_word_valid,
    output logic        o_word_ready,
    output logic [1:0]  o_WrCE,
    output logic [3:0]  o_BE,
    output logic [31:0] o_Data,
    input  logic        i_WrAck,
    input  logic        i_irq,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [31:0] PWR_LAST = (PWR_WAIT_CYC > 0) ? 32'(PWR_WAIT_CYC - 1) : 32'd0;
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);

    state_t      state, next_state;
    logic [31:0] cnt;
    logic [7:0]  rom_idx;
    word_t       word_q;
    logic        init_done, err;

    logic        wr_start, wr_done, wr_timeout;
    logic [1:0]  wr_ce;
    logic [31:0] wr_data;
    logic        load_rom, accept, set_done, restart;
    logic        irq_timeout;

    assign irq_timeout = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state     <= S_IDLE;
            cnt       <= 32'h0;
            rom_idx   <= 8'h0;
            word_q    <= 9'h0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? 32'h0 : cnt + 32'd1;
            if (restart) begin
                rom_idx   <= 8'h0;
                init_done <= 1'b0;
                err       <= 1'b0;
            end
            if (load_rom) begin
                word_q  <= init_rom(rom_idx);
                rom_idx <= rom_idx + 8'd1;
            end
            if (accept)
                word_q <= i_word;
            if (set_done)
                init_done <= 1'b1;
            if (next_state == S_ERROR && state != S_ERROR)
                err <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        load_rom   = 1'b0;
        accept     = 1'b0;
        set_done   = 1'b0;
        restart    = 1'b0;
        wr_start   = 1'b0;
        wr_ce      = 2'b00;
        wr_data    = 32'h0;

        case (state)
            S_IDLE, S_ERROR: begin
                if (i_start) begin
                    next_state = S_PWR_WAIT;
                    restart    = 1'b1;
                end
            end
            S_READY: begin
                if (i_start) begin
                    next_state = S_PWR_WAIT;
                    restart    = 1'b1;
                end else if (i_word_valid) begin
                    next_state = S_WR_GO;
                    accept     = 1'b1;
                end
            end
            S_PWR_WAIT: begin
                if (cnt >= PWR_LAST)
                    next_state = S_FETCH;
            end
            S_FETCH: begin
                if ({24'd0, rom_idx} < 32'(INIT_LEN)) begin
                    next_state = S_WR_GO;
                    load_rom   = 1'b1;
                end else begin
                    next_state = S_READY;
                    set_done   = 1'b1;
                end
            end
            S_WR_GO: begin
                if (wr_timeout)   next_state = S_ERROR;
                else if (wr_done) next_state = S_WR_DAT;
            end
            S_WR_DAT: begin
                if (wr_timeout)   next_state = S_ERROR;
                else if (wr_done) next_state = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                if (i_irq)            next_state = S_WR_CLR;
                else if (irq_timeout) next_state = S_ERROR;
            end
            S_WR_CLR: begin
                if (wr_timeout)   next_state = S_ERROR;
                else if (wr_done) next_state = S_GAP;
            end
            S_GAP: begin
                next_state = init_done ? S_READY : S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase

        // Launch the bus write on the edge that enters a write state.
        if (next_state != state) begin
            case (next_state)
                S_WR_GO: begin
                    wr_start = 1'b1;
                    wr_ce    = CE_CTRL;
                    wr_data  = CTRL_GO;
                end
                S_WR_DAT: begin
                    wr_start = 1'b1;
                    wr_ce    = CE_DATA;
                    wr_data  = {23'd0, word_q};
                end
                S_WR_CLR: begin
                    wr_start = 1'b1;
                    wr_ce    = CE_CTRL;
                    wr_data  = CTRL_CLR;
                end
                default: ;
            endcase
        end
    end

    lcd_seq_buswr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_buswr (
        .clk     (Bus2IP_Clk),
        .rst     (Bus2IP_Reset),
        .start   (wr_start),
        .ce      (wr_ce),
        .data    (wr_data),
        .ack     (i_WrAck),
        .wr_ce   (o_WrCE),
        .be      (o_BE),
        .wr_data (o_Data),
        .done    (wr_done),
        .timeout (wr_timeout)
    );

    assign o_word_ready = (state == S_READY);
    assign o_busy       = !(state == S_IDLE || state == S_READY || state == S_ERROR);
    assign o_init_done  = init_done;
    assign o_err        = err;

endmodule

// File: tb/tb_lcd_spi_seq.sv
// Directed bench for lcd_spi_seq with a small LCD_if responder model that
// acks writes, raises the completion irq and logs every accepted write.
module tb_lcd_spi_seq;

    logic        Bus2IP_Clk   = 1'b0;
    logic        Bus2IP_Reset = 1'b1;
    logic        i_start      = 1'b0;
    logic [8:0]  i_word       = 9'h0;
    logic        i_word_valid = 1'b0;
    logic        i_WrAck      = 1'b0;
    logic        i_irq        = 1'b0;
    logic        o_word_ready;
    logic [1:0]  o_WrCE;
    logic [3:0]  o_BE;
    logic [31:0] o_Data;
    logic        o_init_done;
    logic        o_busy;
    logic        o_err;

    int vectors     = 0;
    int miscompares = 0;

    int ack_delay    = 2;
    int irq_delay    = 40;
    bit ack_withhold = 1'b0;
    bit irq_force    = 1'b0;
    int ce_cnt       = 0;
    int irq_timer    = 0;
    bit ack_prev     = 1'b0;
    bit irq_arm      = 1'b0;
    bit irq_pend     = 1'b0;
    int gap_viol     = 0;
    int be_bad       = 0;

    logic [1:0]  log_ce[$];
    logic [31:0] log_data[$];

    logic [8:0] exp_rom [11] = '{9'h040, 9'h0A1, 9'h0C0, 9'h0A4, 9'h0A6, 9'h0A2,
                                 9'h02F, 9'h027, 9'h081, 9'h010, 9'h0AF};

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    lcd_spi_seq #(
        .PWR_WAIT_CYC (16),
        .TIMEOUT_CYC  (1024),
        .CTRL_GO      (32'h0000_0E04),
        .CTRL_CLR     (32'h0000_0F01),
        .INIT_LEN     (11)
    ) dut (
        .Bus2IP_Clk   (Bus2IP_Clk),
        .Bus2IP_Reset (Bus2IP_Reset),
        .i_start      (i_start),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .o_WrCE       (o_WrCE),
        .o_BE         (o_BE),
        .o_Data       (o_Data),
        .i_WrAck      (i_WrAck),
        .i_irq        (i_irq),
        .o_init_done  (o_init_done),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    // LCD_if responder: ack after ack_delay asserted cycles, irq irq_delay
    // cycles after a data write, irq cleared by the CTRL_CLR write.
    always @(negedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            ce_cnt   = 0;
            ack_prev = 1'b0;
            irq_arm  = 1'b0;
            irq_pend = 1'b0;
            i_WrAck  = 1'b0;
        end else begin
            if (o_WrCE != 2'b00) begin
                if (ack_prev) gap_viol++;
                ce_cnt++;
                i_WrAck = !ack_withhold && (ce_cnt >= ack_delay);
                if (i_WrAck) begin
                    log_ce.push_back(o_WrCE);
                    log_data.push_back(o_Data);
                    if (o_BE != 4'hF) be_bad++;
                    if (o_WrCE == 2'b10) begin
                        irq_arm   = 1'b1;
                        irq_timer = irq_delay;
                    end
                    if (o_WrCE == 2'b01 && o_Data == 32'h0000_0F01) begin
                        irq_pend = 1'b0;
                        irq_arm  = 1'b0;
                    end
                end
            end else begin
                ce_cnt  = 0;
                i_WrAck = 1'b0;
            end
            ack_prev = i_WrAck;
            if (irq_arm) begin
                if (irq_timer <= 1) begin
                    irq_pend = 1'b1;
                    irq_arm  = 1'b0;
                end else begin
                    irq_timer--;
                end
            end
        end
        i_irq = irq_force || irq_pend;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkEntry(input string tag, input int i, input logic [1:0] ce, input logic [31:0] d);
        logic [31:0] a_ce, a_d;
        a_ce = (i < log_ce.size())   ? {30'd0, log_ce[i]} : 32'hDEAD_DEAD;
        a_d  = (i < log_data.size()) ? log_data[i]        : 32'hDEAD_DEAD;
        checkOutput($sformatf("%s_ce[%0d]", tag, i), a_ce, {30'd0, ce});
        checkOutput($sformatf("%s_data[%0d]", tag, i), a_d, d);
    endtask

    task automatic checkWordSeq(input string tag, input int base, input logic [8:0] w);
        checkEntry(tag, base,     2'b01, 32'h0000_0E04);
        checkEntry(tag, base + 1, 2'b10, {23'd0, w});
        checkEntry(tag, base + 2, 2'b01, 32'h0000_0F01);
    endtask

    task automatic pulseStart();
        @(negedge Bus2IP_Clk);
        i_start = 1'b1;
        @(posedge Bus2IP_Clk);
        #1 i_start = 1'b0;
    endtask

    task automatic waitReady(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(posedge Bus2IP_Clk);
            #1 cyc++;
        end while (!o_word_ready && cyc < max_cyc);
        checkOutput(tag, {31'd0, o_word_ready}, 32'd1);
    endtask

    task automatic waitInitDone(input string tag);
        int n = 0;
        while (!o_init_done && n < 4000) begin
            @(posedge Bus2IP_Clk);
            #1 n++;
        end
        checkOutput(tag, {31'd0, o_init_done}, 32'd1);
    endtask

    // Present one user word at a negedge while ready; returns just after the accepting edge.
    task automatic applyStimulus(input logic [8:0] w);
        int n = 0;
        @(negedge Bus2IP_Clk);
        while (!o_word_ready && n < 5000) begin
            @(negedge Bus2IP_Clk);
            n++;
        end
        checkOutput("ready_before_word", {31'd0, o_word_ready}, 32'd1);
        i_word       = w;
        i_word_valid = 1'b1;
        @(posedge Bus2IP_Clk);
        #1;
        i_word_valid = 1'b0;
        i_word       = 9'h0AA;
    endtask

    initial begin
        int cyc;
        int n;

        // Reset state
        repeat (3) @(posedge Bus2IP_Clk);
        #1;
        checkOutput("rst_wrce", {30'd0, o_WrCE}, 32'd0);
        checkOutput("rst_be", {28'd0, o_BE}, 32'd0);
        checkOutput("rst_data", o_Data, 32'd0);
        checkOutput("rst_flags", {27'd0, o_word_ready, o_init_done, o_busy, o_err, 1'b0}, 32'd0);
        @(negedge Bus2IP_Clk);
        Bus2IP_Reset = 1'b0;

        // Power wait and init table
        $display("[TB] init sequence");
        pulseStart();
        checkOutput("pwr_busy", {31'd0, o_busy}, 32'd1);
        cyc = 0;
        while (o_WrCE == 2'b00 && cyc < 100) begin
            @(posedge Bus2IP_Clk);
            #1 cyc++;
        end
        checkOutput("pwr_wait_17_18", {31'd0, (cyc >= 17 && cyc <= 18)}, 32'd1);
        checkOutput("first_wrce", {30'd0, o_WrCE}, 32'd1);
        waitInitDone("init_done");
        @(posedge Bus2IP_Clk);
        #1;
        checkOutput("init_ready", {31'd0, o_word_ready}, 32'd1);
        checkOutput("init_log_len", log_ce.size(), 32'd33);
        for (int i = 0; i < 11; i++)
            checkWordSeq("init", 3 * i, exp_rom[i]);

        // Single user word, i_word changed after acceptance
        $display("[TB] user word 0x137");
        log_ce.delete();
        log_data.delete();
        applyStimulus(9'h137);
        checkOutput("w137_ready_low", {31'd0, o_word_ready}, 32'd0);
        waitReady("w137_ready_back", 500, cyc);
        checkOutput("w137_log_len", log_ce.size(), 32'd3);
        checkWordSeq("w137", 0, 9'h137);

        // Back-to-back words with valid held high
        $display("[TB] back-to-back words");
        log_ce.delete();
        log_data.delete();
        @(negedge Bus2IP_Clk);
        i_word       = 9'h1F2;
        i_word_valid = 1'b1;
        @(posedge Bus2IP_Clk);
        #1 i_word = 9'h155;
        n = 0;
        @(negedge Bus2IP_Clk);
        while (!o_word_ready && n < 500) begin
            @(negedge Bus2IP_Clk);
            n++;
        end
        @(posedge Bus2IP_Clk);
        #1;
        i_word_valid = 1'b0;
        i_word       = 9'h000;
        waitReady("b2b_ready_back", 500, cyc);
        checkOutput("b2b_log_len", log_ce.size(), 32'd6);
        checkWordSeq("b2b_a", 0, 9'h1F2);
        checkWordSeq("b2b_b", 3, 9'h155);
        checkOutput("gap_violations", gap_viol, 32'd0);
        checkOutput("be_violations", be_bad, 32'd0);

        // Zero-wait ack, irq already high, i_start during WR_DAT
        $display("[TB] minimum latency word");
        log_ce.delete();
        log_data.delete();
        ack_delay = 1;
        irq_force = 1'b1;
        applyStimulus(9'h0C3);
        @(posedge Bus2IP_Clk);
        #1;
        @(posedge Bus2IP_Clk);
        #1 i_start = 1'b1;
        @(posedge Bus2IP_Clk);
        #1 i_start = 1'b0;
        waitReady("minlat_ready", 100, cyc);
        checkOutput("minlat_cycles", cyc + 3, 32'd8);
        checkOutput("start_ignored_done", {31'd0, o_init_done}, 32'd1);
        checkWordSeq("minlat", 0, 9'h0C3);
        irq_force = 1'b0;
        ack_delay = 2;

        // Withheld ack: timeout into ERROR, then restart
        $display("[TB] ack timeout");
        ack_withhold = 1'b1;
        applyStimulus(9'h011);
        repeat (1000) @(posedge Bus2IP_Clk);
        #1;
        checkOutput("to_err_early", {31'd0, o_err}, 32'd0);
        checkOutput("to_wrce_held", {30'd0, o_WrCE}, 32'd1);
        repeat (30) @(posedge Bus2IP_Clk);
        #1;
        checkOutput("to_err", {31'd0, o_err}, 32'd1);
        checkOutput("to_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("to_bus", {26'd0, o_WrCE, o_BE}, 32'd0);
        checkOutput("to_data", o_Data, 32'd0);
        ack_withhold = 1'b0;
        log_ce.delete();
        log_data.delete();
        pulseStart();
        checkOutput("restart_err_clr", {30'd0, o_err, o_init_done}, 32'd0);
        waitInitDone("reinit_done");
        checkOutput("reinit_log_len", log_ce.size(), 32'd33);
        checkWordSeq("reinit_last", 30, 9'h0AF);

        // Asynchronous reset in the middle of a data write
        $display("[TB] reset during data write");
        log_ce.delete();
        log_data.delete();
        applyStimulus(9'h0F0);
        n = 0;
        while (o_WrCE != 2'b10 && n < 100) begin
            @(negedge Bus2IP_Clk);
            n++;
        end
        checkOutput("rst_mid_in_dat", {30'd0, o_WrCE}, 32'd2);
        #2 Bus2IP_Reset = 1'b1;
        #1;
        checkOutput("rst_mid_wrce", {30'd0, o_WrCE}, 32'd0);
        checkOutput("rst_mid_be", {28'd0, o_BE}, 32'd0);
        checkOutput("rst_mid_data", o_Data, 32'd0);
        checkOutput("rst_mid_flags", {28'd0, o_word_ready, o_init_done, o_busy, o_err}, 32'd0);
        @(negedge Bus2IP_Clk);
        Bus2IP_Reset = 1'b0;
        @(posedge Bus2IP_Clk);
        #1;
        checkOutput("rst_mid_idle", {31'd0, o_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
